counter_monitor: RTL and testbench

- Receive-side checker for the up/down counter family (`counter`, 32-bit, mode input m).
- Samples a counter's count bus and mode every clock, predicts the next value, and flags steps that break the protocol.
- The protocol is +1 when m=1 and -1 when m=0, modulo 2^WIDTH, or 0 after an upstream clear.
- Sits beside any counter instance in test or self-check builds; outputs lock status, error pulse, saturating error count and the last offending value.

---
 rtl/counter_monitor.sv | 133 +++++++++++++
 tb/tb_counter_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// counter_monitor
//   Receive-side checker for the up/down counter family. Samples the observed
//   count bus and mode every clock, predicts the next value (+1 up, -1 down,
//   modulo 2^WIDTH, or 0 after a clear) and flags steps that break that rule.
//
// Ports
//   clk        system clock, all state changes on posedge
//   rst        asynchronous active-low reset
//   en         monitor enable; 0 = ignore bus and return to IDLE
//   m          mode of observed counter (1 = up, 0 = down), same cycle as count_in
//   clr_in     observed counter was cleared this cycle; next expected value is 0
//   count_in   observed count value
//   locked     1 while in LOCK (registered)
//   err_pulse  one-cycle pulse per counted error
//   err_count  saturating number of counted errors
//   last_bad   count_in value of the most recent counted error
//   sticky_err set on the first counted error, cleared only by reset
module counter_monitor #(
    parameter int WIDTH      = 32,
    parameter int ERRW       = 16,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             m,
    input  logic             clr_in,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERRW-1:0]  err_count,
    output logic [WIDTH-1:0] last_bad,
    output logic             sticky_err
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [ERRW-1:0]  ERR_ONE  = ERRW'(1);
    localparam logic [ERRW-1:0]  ERR_MAX  = '1;
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_CNT);

    state_t           state;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] pred;
    logic [3:0]       good_run;
    logic [3:0]       bad_run;
    logic             match;

    // Next expectation from the current sample; natural wrap gives
    // all-ones+1 = 0 and 0-1 = all-ones.
    always_comb begin
        pred = '0;
        if (clr_in)
            pred = '0;
        else if (m)
            pred = count_in + ONE;
        else
            pred = count_in - ONE;
    end

    assign match = (count_in == exp_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            exp_q      <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            last_bad   <= '0;
            sticky_err <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (!en) begin
                // error history is kept across disable
                state    <= IDLE;
                locked   <= 1'b0;
                good_run <= '0;
                bad_run  <= '0;
            end else begin
                // Always re-predict from the current sample: on a match this
                // equals the old chain, on a mismatch it is the resync.
                exp_q <= pred;
                case (state)
                    IDLE: begin
                        state    <= ACQ;
                        good_run <= '0;
                    end
                    ACQ: begin
                        if (match) begin
                            if (good_run + 4'd1 == LOCK_N) begin
                                state    <= LOCK;
                                locked   <= 1'b1;
                                good_run <= '0;
                                bad_run  <= '0;
                            end else begin
                                good_run <= good_run + 4'd1;
                            end
                        end else begin
                            good_run <= '0;
                        end
                    end
                    LOCK: begin
                        if (match) begin
                            bad_run <= '0;
                        end else begin
                            err_pulse  <= 1'b1;
                            last_bad   <= count_in;
                            sticky_err <= 1'b1;
                            if (err_count != ERR_MAX)
                                err_count <= err_count + ERR_ONE;
                            if (bad_run + 4'd1 == UNLOCK_N) begin
                                state    <= ACQ;
                                locked   <= 1'b0;
                                good_run <= '0;
                                bad_run  <= '0;
                            end else begin
                                bad_run <= bad_run + 4'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor
//   Directed scoreboard bench for counter_monitor (WIDTH=32, ERRW=4 so that
//   saturation is reachable). Each driven sample pushes its hand-computed
//   expected outputs; a monitor pops and compares one entry per clock.
module tb_counter_monitor;
    localparam int W  = 32;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          m = 1'b0;
    logic          clr_in = 1'b0;
    logic [W-1:0]  count_in = '0;
    logic          locked, err_pulse, sticky_err;
    logic [EW-1:0] err_count;
    logic [W-1:0]  last_bad;

    counter_monitor #(.WIDTH(W), .ERRW(EW), .LOCK_CNT(4), .UNLOCK_CNT(3)) dut (
        .clk(clk), .rst(rst), .en(en), .m(m), .clr_in(clr_in), .count_in(count_in),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .last_bad(last_bad), .sticky_err(sticky_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic          lk;
        logic          pl;
        logic [EW-1:0] cnt;
        logic [W-1:0]  lb;
        logic          st;
    } exp_t;

    exp_t          sb[$];
    exp_t          me;
    int            checks = 0;
    int            errors = 0;
    int            tag = 0;
    logic [EW-1:0] e_cnt = '0;
    logic [W-1:0]  e_lb = '0;
    logic          e_st = 1'b0;

    task automatic chk(input string nm, input int t, input logic [W-1:0] act, input logic [W-1:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, t, act, ex);
        end
    endtask

    // monitor: outputs after each edge reflect the sample taken at that edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("locked",     me.tag, W'(locked),     W'(me.lk));
            chk("err_pulse",  me.tag, W'(err_pulse),  W'(me.pl));
            chk("err_count",  me.tag, W'(err_count),  W'(me.cnt));
            chk("last_bad",   me.tag, last_bad,       me.lb);
            chk("sticky_err", me.tag, W'(sticky_err), W'(me.st));
        end
    end

    task automatic step(input logic e, input logic mm, input logic c, input logic [W-1:0] v,
                        input logic lk, input logic pl);
        exp_t x;
        @(negedge clk);
        en = e; m = mm; clr_in = c; count_in = v;
        x.tag = tag; x.lk = lk; x.pl = pl; x.cnt = e_cnt; x.lb = e_lb; x.st = e_st;
        sb.push_back(x);
        tag++;
    endtask

    // sample expected to be a counted error, with the hand-computed count
    task automatic bad(input logic mm, input logic c, input logic [W-1:0] v, input logic lk,
                       input logic [EW-1:0] cnt);
        e_cnt = cnt; e_lb = v; e_st = 1'b1;
        step(1'b1, mm, c, v, lk, 1'b1);
    endtask

    // five clean up-count samples from s: lock shows after the fifth
    task automatic acquire(input logic [W-1:0] s);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, s + W'(i), (i == 4), 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // asynchronous reset between edges, outputs checked before any clock
    task automatic async_reset();
        drain();
        @(posedge clk);
        #3;
        rst = 1'b0; en = 1'b0;
        #1;
        chk("rst_locked",  -1, W'(locked),     '0);
        chk("rst_pulse",   -1, W'(err_pulse),  '0);
        chk("rst_count",   -1, W'(err_count),  '0);
        chk("rst_lastbad", -1, last_bad,       '0);
        chk("rst_sticky",  -1, W'(sticky_err), '0);
        @(negedge clk);
        rst = 1'b1;
        e_cnt = '0; e_lb = '0; e_st = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("init_locked",  -1, W'(locked),     '0);
        chk("init_count",   -1, W'(err_count),  '0);
        chk("init_sticky",  -1, W'(sticky_err), '0);
        @(negedge clk);
        rst = 1'b1;

        // 1: clean up-count 0..10, lock after value 4
        for (int v = 0; v <= 10; v++)
            step(1'b1, 1'b1, 1'b0, W'(v), (v >= 4), 1'b0);

        // 2: 7 replaced by 9, then 10, 11 continue -> one error, lock kept
        async_reset();
        for (int v = 0; v <= 6; v++)
            step(1'b1, 1'b1, 1'b0, W'(v), (v >= 4), 1'b0);
        bad(1'b1, 1'b0, 32'd9, 1'b1, 4'd1);
        step(1'b1, 1'b1, 1'b0, 32'd10, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'd11, 1'b1, 1'b0);

        // 3: wrap up through 0, then reverse down through all-ones
        async_reset();
        acquire(32'hFFFF_FFFA);
        step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);

        // 4: frozen at 0x55 -> three errors drop lock; back in ACQ so four
        //    matches relock
        async_reset();
        acquire(32'h50);
        step(1'b1, 1'b1, 1'b0, 32'h55, 1'b1, 1'b0);
        bad(1'b1, 1'b0, 32'h55, 1'b1, 4'd1);
        bad(1'b1, 1'b0, 32'h55, 1'b1, 4'd2);
        bad(1'b1, 1'b0, 32'h55, 1'b0, 4'd3);
        for (int v = 'h56; v <= 'h59; v++)
            step(1'b1, 1'b1, 1'b0, W'(v), (v == 'h59), 1'b0);

        // 5: clear while locked -> 0, 1 fine; 0x21 after clear is an error;
        //    clear with a wrong value still counts
        async_reset();
        acquire(32'h1B);
        step(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h01, 1'b1, 1'b0);
        async_reset();
        acquire(32'h1B);
        step(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 1'b0);
        bad(1'b1, 1'b0, 32'h21, 1'b1, 4'd1);
        step(1'b1, 1'b1, 1'b0, 32'h22, 1'b1, 1'b0);
        bad(1'b1, 1'b1, 32'h30, 1'b1, 4'd2);
        step(1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h01, 1'b1, 1'b0);

        // 6: 20 isolated errors saturate at 15, then async reset mid-stream
        async_reset();
        acquire(32'h0);
        for (int i = 0; i < 20; i++) begin
            bad(1'b1, 1'b0, W'(32'h100 + i * 16), 1'b1, (i >= 14) ? 4'd15 : EW'(i + 1));
            step(1'b1, 1'b1, 1'b0, W'(32'h101 + i * 16), 1'b1, 1'b0);
        end
        async_reset();

        // disable for two cycles: lock drops, error history held; re-enable
        // goes through IDLE/ACQ with no error for the mismatch
        acquire(32'h70);
        bad(1'b1, 1'b0, 32'h77, 1'b1, 4'd1);
        step(1'b0, 1'b1, 1'b0, 32'h78, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h79, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0999, 1'b0, 1'b0);

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
